// File: rtl/guess_round_ctrl_if.sv
// Handshake and result bundle between player input logic, the round
// sequencer and the score display.
interface guess_round_ctrl_if #(
    parameter int N      = 8,
    parameter int ROUNDS = 5
);
    localparam int RW = $clog2(ROUNDS + 1);

    logic                  tgt_load;
    logic [N-1:0]          tgt_num;
    logic                  p1_valid;
    logic [N-1:0]          p1_num;
    logic                  p1_ready;
    logic                  p2_valid;
    logic [N-1:0]          p2_num;
    logic                  p2_ready;
    logic                  busy;
    logic                  res_valid;
    logic [1:0]            Correct_gues;
    logic [2*ROUNDS-1:0]   Out_cr;
    logic [RW-1:0]         round_idx;
    logic                  game_done;
    logic [1:0]            winner;

    modport master (
        output tgt_load, tgt_num, p1_valid, p1_num, p2_valid, p2_num,
        input  p1_ready, p2_ready, busy, res_valid, Correct_gues, Out_cr,
               round_idx, game_done, winner
    );

    modport slave (
        input  tgt_load, tgt_num, p1_valid, p1_num, p2_valid, p2_num,
        output p1_ready, p2_ready, busy, res_valid, Correct_gues, Out_cr,
               round_idx, game_done, winner
    );
endinterface

// File: rtl/guess_round_ctrl.sv
// Two-player guessing-game round sequencer: collects both guesses, scores them
// bit-serially against the target, keeps per-round history and picks a winner.
module guess_round_ctrl #(
    parameter int N      = 8,
    parameter int ROUNDS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    guess_round_ctrl_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCORE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        tgt_q, tgt_d;
    logic [N-1:0]        g1_q, g1_d;
    logic [N-1:0]        g2_q, g2_d;
    logic                got1_q, got1_d;
    logic                got2_q, got2_d;
    logic [KW-1:0]       k_q, k_d;
    logic [CW-1:0]       c1_q, c1_d;
    logic [CW-1:0]       c2_q, c2_d;
    logic [RW-1:0]       t1_q, t1_d;
    logic [RW-1:0]       t2_q, t2_d;
    logic [RW-1:0]       round_q, round_d;
    logic [2*ROUNDS-1:0] out_cr_q, out_cr_d;
    logic [1:0]          correct_q, correct_d;
    logic                res_valid_q, res_valid_d;

    logic                p1_ready, p2_ready;
    logic                acc1, acc2;
    logic [CW-1:0]       c1_inc, c2_inc;
    logic [RW-1:0]       round_inc;
    logic [ROUNDS-1:0]   hist_sel;

    // Ready comes only from registered state, never from valid.
    assign p1_ready = (state_q == COLLECT) && !got1_q;
    assign p2_ready = (state_q == COLLECT) && !got2_q;
    assign acc1     = bus.p1_valid && p1_ready;
    assign acc2     = bus.p2_valid && p2_ready;

    assign c1_inc    = c1_q + CW'(g1_q[k_q] == tgt_q[k_q]);
    assign c2_inc    = c2_q + CW'(g2_q[k_q] == tgt_q[k_q]);
    assign round_inc = round_q + 1'b1;

    generate
        for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_hist_sel
            assign hist_sel[gi] = (round_q == RW'(gi));
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        g1_d        = g1_q;
        g2_d        = g2_q;
        got1_d      = got1_q;
        got2_d      = got2_q;
        k_d         = k_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        round_d     = round_q;
        out_cr_d    = out_cr_q;
        correct_d   = correct_q;
        res_valid_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.tgt_load) begin
                    tgt_d    = bus.tgt_num;
                    out_cr_d = '0;
                    round_d  = '0;
                    t1_d     = '0;
                    t2_d     = '0;
                    got1_d   = 1'b0;
                    got2_d   = 1'b0;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (acc1) begin
                    g1_d   = bus.p1_num;
                    got1_d = 1'b1;
                end
                if (acc2) begin
                    g2_d   = bus.p2_num;
                    got2_d = 1'b1;
                end
                if ((got1_q || acc1) && (got2_q || acc2)) begin
                    k_d     = '0;
                    c1_d    = '0;
                    c2_d    = '0;
                    state_d = SCORE;
                end
            end
            SCORE: begin
                c1_d = c1_inc;
                c2_d = c2_inc;
                k_d  = k_q + 1'b1;
                if (k_q == KW'(N - 1)) begin
                    correct_d = {c2_inc == CW'(N), c1_inc == CW'(N)};
                    for (int r = 0; r < ROUNDS; r++) begin
                        if (hist_sel[r]) begin
                            out_cr_d[2*r]   = (c1_inc >= c2_inc);
                            out_cr_d[2*r+1] = (c1_inc <= c2_inc);
                        end
                    end
                    if (c1_inc > c2_inc) t1_d = t1_q + 1'b1;
                    if (c2_inc > c1_inc) t2_d = t2_q + 1'b1;
                    round_d     = round_inc;
                    res_valid_d = 1'b1;
                    got1_d      = 1'b0;
                    got2_d      = 1'b0;
                    state_d     = (round_inc == RW'(ROUNDS)) ? DONE : COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            g1_q        <= '0;
            g2_q        <= '0;
            got1_q      <= 1'b0;
            got2_q      <= 1'b0;
            k_q         <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            round_q     <= '0;
            out_cr_q    <= '0;
            correct_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            g1_q        <= g1_d;
            g2_q        <= g2_d;
            got1_q      <= got1_d;
            got2_q      <= got2_d;
            k_q         <= k_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            round_q     <= round_d;
            out_cr_q    <= out_cr_d;
            correct_q   <= correct_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.p1_ready     = p1_ready;
    assign bus.p2_ready     = p2_ready;
    assign bus.busy         = (state_q == SCORE);
    assign bus.game_done    = (state_q == DONE);
    assign bus.res_valid    = res_valid_q;
    assign bus.Correct_gues = correct_q;
    assign bus.Out_cr       = out_cr_q;
    assign bus.round_idx    = round_q;
    assign bus.winner       = (state_q != DONE) ? 2'b00 :
                              (t1_q > t2_q)     ? 2'b01 :
                              (t2_q > t1_q)     ? 2'b10 : 2'b11;
endmodule

// File: tb/tb_guess_round_ctrl.sv
// Scoreboard bench for guess_round_ctrl: directed rounds push expected results,
// a negedge monitor pops and compares whenever res_valid is seen.
module tb_guess_round_ctrl;
    localparam int N      = 8;
    localparam int ROUNDS = 5;
    localparam int RW     = $clog2(ROUNDS + 1);

    typedef struct {
        logic [1:0]          correct;
        logic [2*ROUNDS-1:0] out_cr;
        logic [RW-1:0]       rnd;
        string               name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    guess_round_ctrl_if #(.N(N), .ROUNDS(ROUNDS)) bus ();

    guess_round_ctrl #(.N(N), .ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    time  accept_t = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: every res_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.res_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_result", "res_valid=1 with no round outstanding");
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_correct"}, 32'(bus.Correct_gues), 32'(e.correct));
                check({e.name, "_out_cr"},  32'(bus.Out_cr),       32'(e.out_cr));
                check({e.name, "_round"},   32'(bus.round_idx),    32'(e.rnd));
                check({e.name, "_latency"}, 32'($time - accept_t), 32'(N * 10 + 5));
                $display("result %s: Correct_gues=%b Out_cr=%h round_idx=%0d",
                         e.name, bus.Correct_gues, bus.Out_cr, bus.round_idx);
            end
        end
    end

    task automatic load(input logic [N-1:0] t);
        @(negedge clk);
        bus.tgt_num  = t;
        bus.tgt_load = 1'b1;
        @(negedge clk);
        bus.tgt_load = 1'b0;
        $display("load target=%h", t);
    endtask

    // lead > 0: p1 is offered lead cycles before p2 and keeps valid high
    // (with a different value) to prove it is not re-captured.
    task automatic do_round(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                            input int lead, input logic [1:0] ec,
                            input logic [2*ROUNDS-1:0] eo, input logic [RW-1:0] er);
        exp_t e;
        bit   d1, d2, r1, r2;
        int   cyc;
        d1 = 1'b0; d2 = 1'b0; cyc = 0;
        e.correct = ec; e.out_cr = eo; e.rnd = er; e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        bus.p1_num = a; bus.p1_valid = 1'b1;
        if (lead == 0) begin
            bus.p2_num = b; bus.p2_valid = 1'b1;
        end
        while (!(d1 && d2) && cyc < 50) begin
            r1 = bus.p1_valid && bus.p1_ready;
            r2 = bus.p2_valid && bus.p2_ready;
            @(posedge clk);
            if (r1) d1 = 1'b1;
            if (r2) d2 = 1'b1;
            if (d1 && d2) accept_t = $time;
            @(negedge clk);
            cyc++;
            if (d1 && !d2) begin
                check({name, "_p1_ready_low"}, 32'(bus.p1_ready), 32'd0);
                bus.p1_num = ~a;
            end
            if (lead > 0 && cyc == lead) begin
                bus.p2_num = b; bus.p2_valid = 1'b1;
            end
            if (d2 && !d1) bus.p2_valid = 1'b0;
        end
        bus.p1_valid = 1'b0;
        bus.p2_valid = 1'b0;
        if (!(d1 && d2)) begin
            fail_now({name, "_accept"}, "guesses not accepted within 50 cycles");
            void'(exp_q.pop_back());
        end else begin
            check({name, "_busy"}, 32'({bus.busy, bus.p1_ready, bus.p2_ready}), 32'b100);
            for (int i = 0; i < 4 * N && exp_q.size() > 0; i++) @(negedge clk);
            if (exp_q.size() > 0) begin
                fail_now({name, "_result"}, "no res_valid within cycle budget");
                exp_q.delete();
            end
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.p1_ready, bus.p2_ready, bus.busy, bus.res_valid, bus.Correct_gues,
                    bus.Out_cr, bus.round_idx, bus.game_done, bus.winner});
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tgt_load = 1'b0; bus.tgt_num = '0;
        bus.p1_valid = 1'b0; bus.p1_num = '0;
        bus.p2_valid = 1'b0; bus.p2_num = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'({bus.p1_ready, bus.p2_ready}), 32'd0);

        // Game 1: ends in a 2-2 tie.
        load(8'hA5);
        check("collect_ready", 32'({bus.p1_ready, bus.p2_ready}), 32'b11);
        do_round("g1r0_same_edge", 8'hA5, 8'h5A, 0, 2'b01, 10'h001, 3'd1);
        do_round("g1r1_tie",       8'h0F, 8'h0F, 0, 2'b00, 10'h00D, 3'd2);
        do_round("g1r2_p1_lead",   8'hA4, 8'h00, 3, 2'b00, 10'h01D, 3'd3);
        do_round("g1r3_p2_exact",  8'h5A, 8'hA5, 0, 2'b10, 10'h09D, 3'd4);
        do_round("g1r4_p2",        8'h00, 8'hA1, 0, 2'b00, 10'h29D, 3'd5);
        check("g1_done", 32'({bus.game_done, bus.winner, bus.p1_ready, bus.p2_ready}), 32'b11100);

        // Game 2: p1 wins 3-2.
        load(8'hFF);
        check("g2_restart", 32'({bus.Out_cr, bus.round_idx, bus.game_done}), 32'd0);
        do_round("g2r0_p2_exact", 8'h00, 8'hFF, 0, 2'b10, 10'h002, 3'd1);
        bus.tgt_num = 8'h00; bus.tgt_load = 1'b1;
        do_round("g2r1_load_ign", 8'hFF, 8'h0F, 0, 2'b01, 10'h006, 3'd2);
        bus.tgt_load = 1'b0;
        do_round("g2r2_p1",       8'hFE, 8'hF0, 0, 2'b00, 10'h016, 3'd3);
        do_round("g2r3_p2",       8'h01, 8'h03, 0, 2'b00, 10'h096, 3'd4);
        do_round("g2r4_p1_exact", 8'hFF, 8'h3F, 0, 2'b01, 10'h196, 3'd5);
        check("g2_done", 32'({bus.game_done, bus.winner, bus.p1_ready, bus.p2_ready}), 32'b10100);

        // A sixth guess while DONE must not be accepted.
        bus.p1_num = 8'h11; bus.p1_valid = 1'b1;
        bus.p2_num = 8'h22; bus.p2_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("done_no_accept", 32'({bus.p1_ready, bus.p2_ready, bus.busy, bus.round_idx}), 32'd5);
        bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;

        load(8'hA5);
        check("g3_restart", 32'({bus.Out_cr, bus.round_idx, bus.game_done, bus.winner}), 32'd0);
        check("g3_correct_hold", 32'(bus.Correct_gues), 32'b01);

        // Asynchronous reset in the middle of scoring.
        @(negedge clk);
        bus.p1_num = 8'hA5; bus.p1_valid = 1'b1;
        bus.p2_num = 8'hA5; bus.p2_valid = 1'b1;
        @(negedge clk);
        bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 32'({bus.p1_ready, bus.p2_ready, bus.busy, bus.round_idx}), 32'd0);
        load(8'h3C);
        check("post_reset_ready", 32'({bus.p1_ready, bus.p2_ready}), 32'b11);
        do_round("g4r0", 8'h3C, 8'hC3, 0, 2'b01, 10'h001, 3'd1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/guess_round_ctrl.md
# guess_round_ctrl

Round sequencer for the two-player bit-correlation guessing game. It holds the target, collects one guess per player through valid/ready handshakes, and scores each guess serially one bit per cycle. It then reports the per-round exact-match flags, records a 2-bit comparison per round in a history vector, and declares the game winner after ROUNDS rounds. It sits between the player input logic and the score display.

## Interface
- N, 8: guess/target width in bits (N ≥ 2)
- ROUNDS, 5: rounds per game; history width is 2*ROUNDS
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- tgt_load  in  1  load tgt_num and start a game (honoured in IDLE and DONE only)
- tgt_num  in  N  target value
- p1_valid  in  1  player 1 guess valid
- p1_num  in  N  player 1 guess
- p1_ready  out  1  player 1 guess can be accepted
- p2_valid / p2_num / p2_ready: same as player 1, for player 2
- busy  out  1  high while in SCORE
- res_valid  out  1  one-cycle pulse when a round result is registered
- Correct_gues  out  2  bit0 = player 1 exact match, bit1 = player 2 exact match (last round)
- Out_cr  out  2*ROUNDS  history; bits [2r+1:2r] hold round r
- round_idx  out  clog2(ROUNDS+1)  completed rounds this game
- game_done  out  1  high in DONE
- winner  out  2  01 = p1, 10 = p2, 11 = tie; valid while game_done

## Operation
- States: IDLE, COLLECT, SCORE, DONE. Reset → IDLE.
- IDLE: readies low. tgt_load → capture target, clear history/round_idx/win tallies, go to COLLECT.
- COLLECT:
  - pX_ready is high while that player's guess is not yet captured.
  - A guess is accepted on an edge where pX_valid && pX_ready; it is captured into a holding register.
  - Both players may be accepted on the same edge.
  - Once both are captured (including a same-edge capture) → SCORE.
  - tgt_load is ignored.
- SCORE: busy = 1, readies low, tgt_load ignored.
  - Bit counter k runs 0..N-1, one bit per cycle.
  - c1 += (g1[k] == tgt[k]); c2 += (g2[k] == tgt[k]).
  - c1 and c2 are clog2(N+1) bits wide and are cleared on entry.
- End of scoring, on the edge that processes bit N-1:
  - Correct_gues = {c2==N, c1==N}.
  - Out_cr[2r] = (c1 >= c2); Out_cr[2r+1] = (c1 <= c2), where r = round_idx.
  - p1 tally increments if c1 > c2; p2 tally increments if c2 > c1.
  - round_idx increments; res_valid = 1 for the following cycle.
  - If round_idx becomes ROUNDS → DONE; else → COLLECT with both capture flags cleared.
- DONE:
  - game_done = 1, readies low.
  - winner: 01 if p1 tally > p2 tally, 10 if p2 tally > p1 tally, 11 if equal.
  - tgt_load → same as from IDLE (history, round_idx, tallies cleared; Correct_gues holds its old value until the next result), go to COLLECT; game_done drops.
- Out_cr bits for rounds not yet played read 0. Correct_gues holds its value between results.
- Guesses presented while the corresponding ready is low are not captured; the holding register is unchanged.

## Timing
- Reset: all outputs 0; state IDLE; all internal registers 0. Reset is asynchronous, so assertion mid-SCORE aborts the round immediately and returns to IDLE; the partial round is not recorded.
- Handshake: ready is a registered function of state/capture flags and does not depend combinationally on valid.
- Latency:
  - Second guess accepted at edge E0; SCORE spans edges E1..EN.
  - Results update at EN; res_valid is high from EN to EN+1.
  - The state is already COLLECT (readies high) in that cycle, so the next round's guesses can be accepted at EN+1.
- Throughput: one round per N+1 cycles minimum with both valids held high.
- tgt_load at the same edge as a guess handshake in COLLECT: the guess is accepted and the load is ignored.

## Test plan
- Reset, then tgt_load with tgt=8'hA5; same-edge p1=8'hA5, p2=8'h5A → 8 cycles later res_valid pulses, Correct_gues=01, Out_cr[1:0]=2'b01, round_idx=1.
- p1=8'h0F, p2=8'h0F against 8'hA5 (4 matches each) → Correct_gues=00, Out_cr[3:2]=2'b11, tallies unchanged.
- p1 valid 3 cycles before p2 → p1_ready drops after its accept, p1 is not re-captured; SCORE starts only after p2 is accepted; latency is measured from p2's accept.
- Five rounds, p1 winning 3 and p2 winning 2 → game_done=1, winner=01, readies low; a sixth valid is not accepted; tgt_load restarts with Out_cr=0 and round_idx=0.
- reset driven low at cycle 4 of SCORE → outputs 0 asynchronously, state IDLE; after release, tgt_load is required before any ready rises.
- Extra check: p1=8'h00 vs 8'hFF target, p2=8'hFF → Correct_gues=10, Out_cr[1:0]=2'b10.
